// File: rtl/scoreboard.sv
// In-order scoreboard: circular buffer of issued instructions with multi-port
// writeback, head-of-queue commit and youngest-producer operand forwarding.
package scoreboard_pkg;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [7:0]  trans_id;
        logic [3:0]  fu;
        logic [7:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] result;
        logic        valid;
        exception_t  ex;
    } scoreboard_entry_t;

endpackage

module scoreboard
    import scoreboard_pkg::*;
#(
    parameter int unsigned NR_ENTRIES  = 8,
    parameter int unsigned NR_WB_PORTS = 2,
    parameter int unsigned TID_W       = $clog2(NR_ENTRIES)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    input  scoreboard_entry_t                      issue_instr_i,
    input  logic                                   issue_valid_i,
    output logic                                   issue_ready_o,
    output logic [TID_W-1:0]                       issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TID_W-1:0]      wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][63:0]           wb_data_i,
    input  exception_t [NR_WB_PORTS-1:0]           wb_ex_i,
    output scoreboard_entry_t                      commit_instr_o,
    output logic                                   commit_valid_o,
    input  logic                                   commit_ack_i,
    input  logic [4:0]                             rs1_i,
    input  logic [4:0]                             rs2_i,
    output logic                                   rs1_busy_o,
    output logic                                   rs2_busy_o,
    output logic                                   rs1_valid_o,
    output logic                                   rs2_valid_o,
    output logic [63:0]                            rs1_o,
    output logic [63:0]                            rs2_o
);

    typedef struct packed {
        logic        busy;
        logic        valid;
        logic [63:0] data;
    } fwd_t;

    scoreboard_entry_t   mem_q [NR_ENTRIES];
    logic [TID_W-1:0]    issue_ptr_q;
    logic [TID_W-1:0]    commit_ptr_q;
    logic [TID_W:0]      cnt_q;
    logic [NR_ENTRIES-1:0] occupied;
    logic                issue_fire;
    logic                commit_fire;
    scoreboard_entry_t   issue_entry;
    logic [4:0]          rs_sel [2];
    fwd_t                fwd [2];

    assign issue_ready_o    = cnt_q < (TID_W+1)'(NR_ENTRIES);
    assign issue_trans_id_o = issue_ptr_q;
    assign issue_fire       = issue_valid_i & issue_ready_o;
    assign commit_instr_o   = mem_q[commit_ptr_q];
    assign commit_valid_o   = (cnt_q != '0) && mem_q[commit_ptr_q].valid;
    assign commit_fire      = commit_ack_i & commit_valid_o;

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        occupied = '0;
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            occupied[i] = {1'b0, TID_W'(i) - commit_ptr_q} < cnt_q;
        end
    end

    always_comb begin
        issue_entry          = issue_instr_i;
        issue_entry.trans_id = 8'(issue_ptr_q);
        issue_entry.valid    = issue_instr_i.ex.valid;
    end

    assign rs_sel[0] = rs1_i;
    assign rs_sel[1] = rs2_i;

    // Walk oldest to youngest so the last match is the youngest producer.
    always_comb begin
        for (int unsigned r = 0; r < 2; r++) begin
            fwd[r] = '0;
            for (int unsigned j = 0; j < NR_ENTRIES; j++) begin
                if (rs_sel[r] != 5'd0 && j < 32'(cnt_q) &&
                    mem_q[TID_W'(32'(commit_ptr_q) + j)].rd == rs_sel[r]) begin
                    fwd[r].busy  = 1'b1;
                    fwd[r].valid = mem_q[TID_W'(32'(commit_ptr_q) + j)].valid;
                    fwd[r].data  = mem_q[TID_W'(32'(commit_ptr_q) + j)].result;
                end
            end
        end
    end

    assign rs1_busy_o  = fwd[0].busy;
    assign rs1_valid_o = fwd[0].valid;
    assign rs1_o       = fwd[0].data;
    assign rs2_busy_o  = fwd[1].busy;
    assign rs2_valid_o = fwd[1].valid;
    assign rs2_o       = fwd[1].data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) mem_q[i] <= '0;
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
            cnt_q        <= '0;
        end else if (flush_i) begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) mem_q[i].valid <= 1'b0;
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
            cnt_q        <= '0;
        end else begin
            // Highest port first so the lowest port's write lands last and wins.
            for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
                if (wb_valid_i[NR_WB_PORTS-1-k] && occupied[wb_trans_id_i[NR_WB_PORTS-1-k]]) begin
                    mem_q[wb_trans_id_i[NR_WB_PORTS-1-k]].result <= wb_data_i[NR_WB_PORTS-1-k];
                    mem_q[wb_trans_id_i[NR_WB_PORTS-1-k]].valid  <= 1'b1;
                    if (wb_ex_i[NR_WB_PORTS-1-k].valid)
                        mem_q[wb_trans_id_i[NR_WB_PORTS-1-k]].ex <= wb_ex_i[NR_WB_PORTS-1-k];
                end
            end
            if (commit_fire) begin
                mem_q[commit_ptr_q].valid <= 1'b0;
                commit_ptr_q              <= commit_ptr_q + 1'b1;
            end
            if (issue_fire) begin
                mem_q[issue_ptr_q] <= issue_entry;
                issue_ptr_q        <= issue_ptr_q + 1'b1;
            end
            case ({issue_fire, commit_fire})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule
